// File: rtl/uart_rx_param.sv
// Oversampled UART receiver: mid-bit sampling, optional parity, 1/2 stop bits,
// false-start rejection, break/framing detection and a one-word output buffer.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_enabled_i,
  input  logic                 in_i,
  input  logic                 s_tick_i,
  output logic [DATA_BITS-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 break_det_o,
  output logic                 overrun_o
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] S_MID       = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END       = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST_DATA = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_LAST_STOP = NW'(STOP_BITS - 1);
  localparam logic          ODD         = 1'(PARITY_ODD);

  // state   | meaning
  // IDLE    | line idle, waiting for a falling edge while enabled
  // START   | confirming the start bit at its middle
  // DATA    | sampling data bits, LSB first
  // PARITY  | sampling the parity bit
  // STOP    | sampling stop bits, commit after the last one
  // RECOVER | line still low after the frame, wait for it to go high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_RECOVER} state_t;

  state_t               state_q;
  logic                 rx_meta_q, rx_s_q;
  logic [SW-1:0]        s_q;
  logic [NW-1:0]        n_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 par_bit_q, perr_q, ferr_q, brk_q;
  logic                 valid_q, busy_q, perr_out_q, ferr_out_q, brk_out_q, ovr_q;

  logic end_tick, first_stop, last_stop, commit_d;
  logic ferr_d, brk_d, perr_d;

  assign end_tick   = s_tick_i && (s_q == S_END);
  assign first_stop = (n_q == '0);
  assign last_stop  = (n_q == N_LAST_STOP);
  assign ferr_d     = ferr_q | ~rx_s_q;
  assign perr_d     = (((^shift_q) ^ rx_s_q) != ODD);
  // Only the first stop bit takes part in break detection.
  assign brk_d      = first_stop ? ((shift_q == '0) && ((PARITY_EN == 0) || !par_bit_q) && !rx_s_q)
                                 : brk_q;
  assign commit_d   = (state_q == S_STOP) && end_tick && last_stop;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      s_q        <= '0;
      n_q        <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      brk_out_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_meta_q <= in_i;
      rx_s_q    <= rx_meta_q;
      ovr_q     <= 1'b0;

      if (valid_q && out_ready_i) valid_q <= 1'b0;
      // A commit overrides the consume above, so consume+commit keeps valid high.
      if (commit_d) begin
        if (!valid_q || out_ready_i) begin
          data_q     <= shift_q;
          perr_out_q <= (PARITY_EN != 0) && perr_q;
          ferr_out_q <= ferr_d;
          brk_out_q  <= brk_d;
          valid_q    <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (!rx_s_q && rx_enabled_i) begin
            state_q <= S_START;
            s_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (s_tick_i) begin
            if (s_q == S_MID) begin
              if (rx_s_q) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DATA;
                s_q     <= '0;
                n_q     <= '0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                brk_q   <= 1'b0;
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        S_DATA: begin
          if (s_tick_i) begin
            if (s_q == S_END) begin
              shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              s_q     <= '0;
              if (n_q == N_LAST_DATA) begin
                n_q     <= '0;
                state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        S_PARITY: begin
          if (s_tick_i) begin
            if (s_q == S_END) begin
              par_bit_q <= rx_s_q;
              perr_q    <= perr_d;
              s_q       <= '0;
              n_q       <= '0;
              state_q   <= S_STOP;
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        S_STOP: begin
          if (s_tick_i) begin
            if (s_q == S_END) begin
              ferr_q <= ferr_d;
              brk_q  <= brk_d;
              s_q    <= '0;
              if (last_stop) begin
                n_q     <= '0;
                state_q <= rx_s_q ? S_IDLE : S_RECOVER;
                busy_q  <= ~rx_s_q;
              end else begin
                n_q <= n_q + NW'(1);
              end
            end else begin
              s_q <= s_q + SW'(1);
            end
          end
        end
        S_RECOVER: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data_o   = data_q;
  assign out_valid_o  = valid_q;
  assign busy_o       = busy_q;
  assign parity_err_o = perr_out_q;
  assign frame_err_o  = ferr_out_q;
  assign break_det_o  = brk_out_q;
  assign overrun_o    = ovr_q;
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 7N2) driven by
// directed and random frames, checked against a frame-level reference model.
module tb_uart_rx_param;
  logic       clk = 1'b0;
  logic       rst, rx_en, out_ready, s_tick;
  logic       line [3];
  logic [2:0] vld_w, busy_w, perr_w, ferr_w, brk_w, ovr_w;
  logic [7:0] dA, dB;
  logic [6:0] dC;

  int div = 1;
  int cyc = 0;
  int start_cyc = 0;
  int checks = 0;
  int errors = 0;

  int nbits_c [3] = '{8, 8, 7};
  int pen_c   [3] = '{0, 1, 0};
  int podd_c  [3] = '{0, 0, 0};
  int nstop_c [3] = '{1, 1, 2};

  bit         mv  [3];
  logic [8:0] md  [3];
  bit         mpe [3], mfe [3], mbk [3];
  int         exp_ov [3];
  int         ov_cnt [3], ov_long [3], rise [3];
  bit         ov_prev [3], v_prev [3];

  uart_rx_param u_a (
    .clk_i(clk), .rst_i(rst), .rx_enabled_i(rx_en), .in_i(line[0]), .s_tick_i(s_tick),
    .out_data_o(dA), .out_valid_o(vld_w[0]), .out_ready_i(out_ready), .busy_o(busy_w[0]),
    .parity_err_o(perr_w[0]), .frame_err_o(ferr_w[0]), .break_det_o(brk_w[0]),
    .overrun_o(ovr_w[0]));

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
    .clk_i(clk), .rst_i(rst), .rx_enabled_i(rx_en), .in_i(line[1]), .s_tick_i(s_tick),
    .out_data_o(dB), .out_valid_o(vld_w[1]), .out_ready_i(out_ready), .busy_o(busy_w[1]),
    .parity_err_o(perr_w[1]), .frame_err_o(ferr_w[1]), .break_det_o(brk_w[1]),
    .overrun_o(ovr_w[1]));

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_c (
    .clk_i(clk), .rst_i(rst), .rx_enabled_i(rx_en), .in_i(line[2]), .s_tick_i(s_tick),
    .out_data_o(dC), .out_valid_o(vld_w[2]), .out_ready_i(out_ready), .busy_o(busy_w[2]),
    .parity_err_o(perr_w[2]), .frame_err_o(ferr_w[2]), .break_det_o(brk_w[2]),
    .overrun_o(ovr_w[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // s_tick: one pulse every div clocks, changed on the falling edge
  initial begin
    int tcnt;
    tcnt = 0;
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      if (tcnt >= div) begin
        s_tick = 1'b1;
        tcnt = 0;
      end else begin
        s_tick = 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      ov_cnt[i] = 0; ov_long[i] = 0; rise[i] = -1; ov_prev[i] = 0; v_prev[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (ovr_w[i] === 1'b1) begin
          ov_cnt[i]++;
          if (ov_prev[i]) ov_long[i]++;
        end
        if (vld_w[i] === 1'b1 && !v_prev[i]) rise[i] = cyc;
        ov_prev[i] = (ovr_w[i] === 1'b1);
        v_prev[i]  = (vld_w[i] === 1'b1);
      end
    end
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: observed timeout, expected bench completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_data(input int sel);
    case (sel)
      0:       return 32'(dA);
      1:       return 32'(dB);
      default: return 32'(dC);
    endcase
  endfunction

  // Frame-level model: decide flags from the bits on the line, then apply buffer rules.
  task automatic model_commit(input int sel, input int data, input bit pbit,
                              input bit s0, input bit s1, input bit rdy);
    logic [8:0] d;
    bit pe, fe, bk;
    d  = 9'(data & ((1 << nbits_c[sel]) - 1));
    pe = (pen_c[sel] != 0) && ((($countones(d) + int'(pbit)) % 2) != podd_c[sel]);
    fe = !s0 || (nstop_c[sel] == 2 && !s1);
    bk = (d == 0) && (pen_c[sel] == 0 || !pbit) && !s0;
    if (!mv[sel] || rdy) begin
      mv[sel] = 1; md[sel] = d; mpe[sel] = pe; mfe[sel] = fe; mbk[sel] = bk;
    end else begin
      exp_ov[sel]++;
    end
  endtask

  task automatic model_consume_all();
    for (int i = 0; i < 3; i++) mv[i] = 0;
  endtask

  task automatic check_inst(input string tag, input int sel);
    check({tag, "_valid"}, 32'(vld_w[sel]), 32'(mv[sel]));
    if (mv[sel]) begin
      check({tag, "_data"}, obs_data(sel), 32'(md[sel]));
      check({tag, "_perr"}, 32'(perr_w[sel]), 32'(mpe[sel]));
      check({tag, "_ferr"}, 32'(ferr_w[sel]), 32'(mfe[sel]));
      check({tag, "_brk"},  32'(brk_w[sel]),  32'(mbk[sel]));
    end
    check({tag, "_ovr"}, 32'(ov_cnt[sel]), 32'(exp_ov[sel]));
    check({tag, "_ovr_len"}, 32'(ov_long[sel]), 32'd0);
  endtask

  task automatic hold_bit(input int sel, input bit v, input int nt);
    int k;
    k = 0;
    line[sel] = v;
    while (k < nt) begin
      @(posedge clk);
      if (s_tick) k++;
    end
    #1;
  endtask

  task automatic send_frame(input int sel, input int data, input bit pbit,
                            input bit s0, input bit s1, input int upto);
    bit bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits_c[sel]; i++) bits.push_back(1'((data >> i) & 1));
    if (pen_c[sel] != 0) bits.push_back(pbit);
    bits.push_back(s0);
    if (nstop_c[sel] == 2) bits.push_back(s1);
    @(posedge clk); #1;
    start_cyc = cyc;
    for (int j = 0; j < bits.size() && j < upto; j++) hold_bit(sel, bits[j], 16);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    model_consume_all();
  endtask

  // clocks from line fall to out_valid: sync + half start bit + one bit per remaining bit
  function automatic int exp_lat(input int sel);
    return 3 + 8 + 16 * (nbits_c[sel] + pen_c[sel] + nstop_c[sel]);
  endfunction

  initial begin
    int sel, d;
    bit pb, s0, s1;
    rst = 1'b1; rx_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1; mv[i] = 0; md[i] = '0; exp_ov[i] = 0; mpe[i] = 0; mfe[i] = 0; mbk[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(vld_w), 32'd0);
    check("rst_busy",  32'(busy_w), 32'd0);
    check("rst_flags", {29'd0, perr_w | ferr_w | brk_w}, 32'd0);
    check("rst_ovr",   32'(ovr_w), 32'd0);
    check("rst_data",  {8'd0, dA, dB, 1'b0, dC}, 32'd0);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;

    // 8N1 0xA5 with exact latency and busy during the frame
    fork
      send_frame(0, 8'hA5, 0, 1, 1, 99);
      begin
        @(posedge clk); #1;
        repeat (60) @(posedge clk);
        #1;
        check("a5_busy_mid", 32'(busy_w[0]), 32'd1);
      end
    join
    model_commit(0, 8'hA5, 0, 1, 1, 0);
    check_inst("a5", 0);
    check("a5_latency", 32'(rise[0] - start_cyc), 32'(exp_lat(0)));
    check("a5_busy_end", 32'(busy_w[0]), 32'd0);
    consume();
    check("a5_consumed", 32'(vld_w[0]), 32'd0);

    // false start: line low for 4 ticks, rejected at the mid-start check
    hold_bit(0, 0, 4);
    line[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_busy_before", 32'(busy_w[0]), 32'd1);
    @(posedge clk); #1;
    check("glitch_idle_after", 32'(busy_w[0]), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("glitch_no_valid", 32'(vld_w[0]), 32'd0);

    // even parity: 0x07 with wrong then right parity bit
    send_frame(1, 8'h07, 0, 1, 1, 99);
    model_commit(1, 8'h07, 0, 1, 1, 0);
    check_inst("par_bad", 1);
    check("par_latency", 32'(rise[1] - start_cyc), 32'(exp_lat(1)));
    consume();
    send_frame(1, 8'h07, 1, 1, 1, 99);
    model_commit(1, 8'h07, 1, 1, 1, 0);
    check_inst("par_good", 1);
    consume();

    // break: 0x00 with low stop, line low 3 more bit times, then a clean 0x3C
    send_frame(0, 8'h00, 0, 0, 0, 99);
    model_commit(0, 8'h00, 0, 0, 0, 0);
    hold_bit(0, 0, 48);
    check_inst("brk", 0);
    check("brk_recover_busy", 32'(busy_w[0]), 32'd1);
    consume();
    hold_bit(0, 1, 32);
    check("brk_no_extra_valid", 32'(vld_w[0]), 32'd0);
    check("brk_idle", 32'(busy_w[0]), 32'd0);
    send_frame(0, 8'h3C, 0, 1, 1, 99);
    model_commit(0, 8'h3C, 0, 1, 1, 0);
    check_inst("after_brk", 0);
    consume();

    // overrun: second frame dropped while the buffer is held
    send_frame(0, 8'h11, 0, 1, 1, 99);
    model_commit(0, 8'h11, 0, 1, 1, 0);
    send_frame(0, 8'h22, 0, 1, 1, 99);
    model_commit(0, 8'h22, 0, 1, 1, 0);
    check_inst("ovr", 0);
    consume();
    check("ovr_consumed", 32'(vld_w[0]), 32'd0);

    // consume on the exact commit cycle: new word loads, no overrun
    send_frame(0, 8'h33, 0, 1, 1, 99);
    model_commit(0, 8'h33, 0, 1, 1, 0);
    fork
      send_frame(0, 8'h44, 0, 1, 1, 99);
      begin
        @(posedge clk); #1;
        repeat (exp_lat(0) - 1) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    join
    model_consume_all();
    model_commit(0, 8'h44, 0, 1, 1, 1);
    check_inst("same_cycle", 0);
    consume();

    // enable gating: no start while disabled; a frame in flight completes
    rx_en = 1'b0;
    send_frame(0, 8'h5A, 0, 1, 1, 99);
    check("dis_no_valid", 32'(vld_w[0]), 32'd0);
    rx_en = 1'b1;
    fork
      send_frame(0, 8'h6B, 0, 1, 1, 99);
      begin
        repeat (50) @(posedge clk);
        #1;
        rx_en = 1'b0;
      end
    join
    model_commit(0, 8'h6B, 0, 1, 1, 0);
    check_inst("dis_midframe", 0);
    rx_en = 1'b1;
    consume();

    // 7 data bits, 2 stop bits, second stop low
    send_frame(2, 7'h55, 0, 1, 0, 99);
    model_commit(2, 7'h55, 0, 1, 0, 0);
    check_inst("c_stop2", 2);
    hold_bit(2, 1, 32);
    send_frame(2, 7'h2A, 0, 1, 1, 3);
    check("c_mid_busy", 32'(busy_w[2]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_consume_all();
    check("c_rst_valid", 32'(vld_w), 32'd0);
    check("c_rst_busy",  32'(busy_w), 32'd0);
    check("c_rst_data",  32'(dC), 32'd0);
    check("c_rst_flags", {29'd0, perr_w | ferr_w | brk_w}, 32'd0);
    hold_bit(2, 1, 32);
    check("c_rst_no_frame", 32'(vld_w[2]), 32'd0);
    d = int'($urandom_range(0, 127));
    send_frame(2, d, 0, 1, 1, 99);
    model_commit(2, d, 0, 1, 1, 0);
    check_inst("c_clean", 2);
    consume();

    // random frames over all configurations and tick rates
    for (int it = 0; it < 10; it++) begin
      sel = int'($urandom_range(0, 2));
      d   = int'($urandom_range(0, 255));
      pb  = 1'($urandom_range(0, 1));
      s0  = ($urandom_range(0, 3) != 0);
      s1  = ($urandom_range(0, 3) != 0);
      div = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) != 0) consume();
      send_frame(sel, d, pb, s0, s1, 99);
      model_commit(sel, d, pb, s0, s1, 0);
      check_inst($sformatf("rnd%0d", it), sel);
      if (line[sel] == 1'b0) hold_bit(sel, 1, 16);
    end
    div = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised next-generation UART receiver. Configurable data width, optional parity, 1 or 2 stop bits and oversample rate. Adds false-start rejection, parity/framing/break detection, and a one-entry output buffer with valid/ready handshake and overrun flag. Sits between the baud-tick generator (s_tick source) and the RX FIFO or register interface.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
OVERSAMPLE, 16, s_tick pulses per bit; even, >= 4
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits checked; legal 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
rx_enabled  input  1  arms start detection
in  input  1  asynchronous serial RX line, idle high
s_tick  input  1  oversample tick, one clk wide
out_data  output  DATA_BITS  received word, LSB first on the line
out_valid  output  1  out_data and the status flags are valid
out_ready  input  1  consumer accepts; transfer when out_valid && out_ready
busy  output  1  frame in progress
parity_err  output  1  parity mismatch on held word (0 if PARITY_EN=0)
frame_err  output  1  a stop bit sampled low on held word
break_det  output  1  held word is a break (all data 0, parity 0 if enabled, first stop 0)
overrun  output  1  one-cycle pulse: completed frame dropped because buffer full

Behaviour:
- Reset: state IDLE; counters 0; shift reg 0; out_data 0; out_valid, busy, parity_err, frame_err, break_det, overrun 0; both sync flops set to 1. Reset mid-frame aborts the frame silently.
- `in` passes through a 2-flop synchroniser (rx_s). All line decisions use rx_s.
- s counter width $clog2(OVERSAMPLE). n counter width $clog2(DATA_BITS+1). Counters advance only on s_tick.
- IDLE: rx_s==0 && rx_enabled -> START, s=0. busy = (state != IDLE), registered.
- START: on tick at s==OVERSAMPLE/2-1, rx_s==1 -> false start, back to IDLE with no output; otherwise -> DATA with s=0, n=0. Other ticks: s++.
- DATA: on tick at s==OVERSAMPLE-1, sample rx_s (mid-bit), shift in from the MSB end (LSB-first), n++, s=0. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: sample at s==OVERSAMPLE-1. perr = (XOR of data ^ sample) != PARITY_ODD. Then -> STOP.
- STOP: sample each stop bit at s==OVERSAMPLE-1. Any low sample sets ferr. Only the first stop bit feeds break detection. After the last stop sample: commit. Then -> IDLE if the last sample was 1, else -> RECOVER.
- RECOVER: wait for rx_s==1, then -> IDLE. This prevents a break or framing error from re-triggering a start.
- Commit (same edge as leaving STOP):
  - If buffer empty, or out_ready is high that cycle: load out_data and the flags, set out_valid=1.
  - Otherwise: keep the old word and flags, pulse overrun for 1 cycle.
- Latency: out_valid rises the clk after the s_tick that samples the last stop bit.
- out_valid stays high until out_valid && out_ready. out_data and the flags are stable while out_valid=1.
- Consume and commit in the same cycle: the new word loads, out_valid stays 1, no overrun.
- Deasserting rx_enabled only blocks new starts. A frame already in progress completes and commits.
- Ticks arriving during RECOVER or IDLE are ignored.

Test Plan:
- Defaults, s_tick every clk, send 0xA5 (8N1, 16 clk/bit) -> out_valid after last stop sample; out_data=0xA5; all error flags 0; busy high for the frame.
- Line low 4 ticks then high (glitch) -> returns to IDLE at tick 7; busy drops; no out_valid.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 (correct is 1) -> out_data=0x07, parity_err=1. Repeat with parity bit 1 -> parity_err=0.
- Send 0x00 with stop bit low, line held low 3 more bit times, then high, then send 0x3C -> first word 0x00 with frame_err=1 and break_det=1; no extra frames during the low period; second word 0x3C, all flags clear.
- out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11; overrun pulses 1 cycle at the second commit; then out_ready=1 -> 0x11 consumed, out_valid drops. Separately, out_ready=1 exactly on the commit cycle -> new word loaded, no overrun.
- DATA_BITS=7, STOP_BITS=2: send 0x55 with second stop bit low -> out_data=0x55, frame_err=1. Assert rst mid-DATA of the next frame -> all outputs 0 the next cycle, and the next clean frame is received correctly.
